// File: rtl/branch_resolve_unit_if.sv
// Valid/ready bundle between the EX operand muxes, the branch
// resolve unit and the fetch redirect logic.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2,
    output in_pc, in_imm, in_pred_taken, flush,
    output out_ready,
    input  in_ready, out_valid, out_taken,
    input  out_mispredict, out_redirect_pc,
    input  out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2,
    input  in_pc, in_imm, in_pred_taken, flush,
    input  out_ready,
    output in_ready, out_valid, out_taken,
    output out_mispredict, out_redirect_pc,
    output out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: compares, decodes funct3, emits redirect.
// Optional statistics counters enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
`ifdef BRU_STATS_EN
  ,
  output logic [CNT_W-1:0]      stat_branches,
  output logic [CNT_W-1:0]      stat_mispredicts
`endif
);

  typedef struct packed {
    logic            eq;
    logic            lt;
    logic            ltu;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc4;
    logic [2:0]      funct3;
    logic            pred;
  } s1_t;

  s1_t             s1_q;
  s1_t             s1_d;
  logic            s1_valid;
  logic            s2_valid;
  logic            s1_adv;
  logic            s2_adv;

  logic            taken_q;
  logic            mis_q;
  logic [XLEN-1:0] redir_q;
  logic            ill_q;

  logic            taken_d;
  logic            mis_d;
  logic [XLEN-1:0] redir_d;
  logic            ill_d;
  logic            cond;

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.in_ready        = s1_adv;
  assign bus.out_valid       = s2_valid;
  assign bus.out_taken       = taken_q;
  assign bus.out_mispredict  = mis_q;
  assign bus.out_redirect_pc = redir_q;
  assign bus.out_illegal     = ill_q;

  always_comb begin
    s1_d        = '0;
    s1_d.eq     = bus.in_rs1 == bus.in_rs2;
    s1_d.lt     = $signed(bus.in_rs1)
                < $signed(bus.in_rs2);
    s1_d.ltu    = bus.in_rs1 < bus.in_rs2;
    s1_d.target = bus.in_pc + bus.in_imm;
    s1_d.pc4    = bus.in_pc + XLEN'(4);
    s1_d.funct3 = bus.in_funct3;
    s1_d.pred   = bus.in_pred_taken;
  end

  // 010/011 fall into default: never taken, flagged illegal
  always_comb begin
    cond  = 1'b0;
    ill_d = 1'b0;
    unique case (s1_q.funct3)
      3'b000:  cond = s1_q.eq;
      3'b001:  cond = !s1_q.eq;
      3'b100:  cond = s1_q.lt;
      3'b101:  cond = !s1_q.lt;
      3'b110:  cond = s1_q.ltu;
      3'b111:  cond = !s1_q.ltu;
      default: ill_d = 1'b1;
    endcase
    taken_d = cond;
    mis_d   = taken_d != s1_q.pred;
    redir_d = taken_d ? s1_q.target : s1_q.pc4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      taken_q  <= 1'b0;
      mis_q    <= 1'b0;
      redir_q  <= '0;
      ill_q    <= 1'b0;
    end else begin
      if (s2_adv && s1_valid) begin
        taken_q <= taken_d;
        mis_q   <= mis_d;
        redir_q <= redir_d;
        ill_q   <= ill_d;
      end
      if (s1_adv && bus.in_valid) begin
        s1_q <= s1_d;
      end
      // flush only kills valids; stale data is harmless
      if (bus.flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_adv) s2_valid <= s1_valid;
        if (s1_adv) s1_valid <= bus.in_valid;
      end
    end
  end

`ifdef BRU_STATS_EN
  logic fire;
  assign fire = s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (fire) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + 1'b1;
      if (mis_q && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed checks of branch_resolve_unit against a
// queue-based latency/outcome model.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  typedef struct {
    logic            taken;
    logic            mis;
    logic [XLEN-1:0] redir;
    logic            ill;
  } exp_t;

  logic clk;
  logic rst;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;
`endif

  branch_resolve_unit #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BRU_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  int   age[$];
  int   m_br  = 0;
  int   m_mis = 0;
  logic hs_in;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [2:0]      f3,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] imm,
    input logic            pred);
    exp_t            e;
    longint          sa;
    longint          sb;
    logic            c;
    logic [XLEN-1:0] t;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'd0:    c = (a == b);
      3'd1:    c = (a != b);
      3'd4:    c = (sa < sb);
      3'd5:    c = (sa >= sb);
      3'd6:    c = (a < b);
      3'd7:    c = (a >= b);
      default: c = 1'b0;
    endcase
    e.ill   = (f3 == 3'd2) || (f3 == 3'd3);
    e.taken = c;
    e.mis   = (c != pred);
    t       = c ? pc + imm : pc + 4;
    e.redir = t;
    return e;
  endfunction

  function automatic int sat(input int v);
    int mx;
    mx = (1 << CNT_W) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_outputs();
    logic ev;
    if (rst) return;
    ev = (q.size() > 0) && (age[0] >= 2);
    chk("out_valid", bus.out_valid, ev);
    chk("in_ready", bus.in_ready,
        !(q.size() == 2 && !bus.out_ready));
    if (ev && bus.out_valid) begin
      chk("taken", bus.out_taken, q[0].taken);
      chk("mispredict", bus.out_mispredict, q[0].mis);
      chk("redirect", bus.out_redirect_pc, q[0].redir);
      chk("illegal", bus.out_illegal, q[0].ill);
    end
`ifdef BRU_STATS_EN
    chk("stat_br", stat_branches, m_br);
    chk("stat_mis", stat_mispredicts, m_mis);
`endif
  endtask

  task automatic tick();
    logic hi, ho, fl, r;
    exp_t e;
    @(negedge clk);
    check_outputs();
    r  = rst;
    fl = bus.flush;
    hi = bus.in_valid && bus.in_ready;
    ho = bus.out_valid && bus.out_ready;
    e  = model(bus.in_funct3, bus.in_rs1, bus.in_rs2,
               bus.in_pc, bus.in_imm, bus.in_pred_taken);
    @(posedge clk);
    hs_in = 1'b0;
    if (r) begin
      q.delete();
      age.delete();
      m_br  = 0;
      m_mis = 0;
    end else begin
      if (ho) begin
        m_br = sat(m_br + 1);
        if (q.size() > 0) begin
          if (q[0].mis) m_mis = sat(m_mis + 1);
          void'(q.pop_front());
          void'(age.pop_front());
        end
      end
      if (fl) begin
        q.delete();
        age.delete();
      end else begin
        foreach (age[i]) age[i]++;
        if (hi) begin
          q.push_back(e);
          age.push_back(1);
          hs_in = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [2:0] f3,
                       input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] imm,
                       input logic pred);
    bus.in_funct3     = f3;
    bus.in_rs1        = a;
    bus.in_rs2        = b;
    bus.in_pc         = pc;
    bus.in_imm        = imm;
    bus.in_pred_taken = pred;
  endtask

  task automatic beat(input logic [2:0] f3,
                      input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] imm,
                      input logic pred);
    bit ok;
    ok = 0;
    drive(f3, a, b, pc, imm, pred);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_in) begin
        ok = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [XLEN-1:0] rnd_op();
    logic [XLEN-1:0] v;
    case ($urandom_range(3))
      0:       v = XLEN'($urandom_range(8));
      1:       v = {1'b1, XLEN'($urandom) >> 1};
      default: v = XLEN'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int              sent;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'd0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_taken", bus.out_taken, 0);
    chk("rst_mis", bus.out_mispredict, 0);
    chk("rst_ill", bus.out_illegal, 0);
    chk("rst_redir", bus.out_redirect_pc, 0);
    @(posedge clk);
    #1;

    beat(3'b000, 5, 5, 32'h100, 32'h20, 1'b0);
    idle(3);
    beat(3'b100, 32'h8000_0000, 1, 32'h200, 32'h40, 1'b0);
    beat(3'b110, 32'h8000_0000, 1, 32'h300, 32'h40, 1'b1);
    beat(3'b011, 7, 9, 32'h400, 32'h10, 1'b1);
    beat(3'b010, 7, 7, 32'hFFFF_FFFC, 32'h8, 1'b0);
    beat(3'b111, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF0,
         32'h20, 1'b0);
    idle(4);

    // 4-beat stream with out_ready dropped for 3 cycles
    sent = 0;
    for (int i = 0; i < 16; i++) begin
      bus.out_ready = !(i >= 3 && i < 6);
      bus.in_valid  = (sent < 4);
      drive(3'(sent + 4), XLEN'(sent), 2,
            XLEN'(32'h1000 + sent * 16), 32'h80, 1'b0);
      tick();
      if (hs_in) sent++;
    end
    chk("stream_sent", sent, 4);
    bus.out_ready = 1'b1;
    idle(3);

    // flush with both stages full and an input handshake
    bus.out_ready = 1'b0;
    beat(3'b001, 1, 2, 32'h500, 32'h8, 1'b0);
    beat(3'b001, 3, 4, 32'h600, 32'h8, 1'b1);
    tick();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    drive(3'b000, 9, 9, 32'h700, 32'h8, 1'b0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    idle(4);

    // saturation, then a reset mid-stream
    for (int i = 0; i < 5; i++)
      beat(3'b000, 5, 5, 32'h800, 32'h4, 1'b0);
    idle(3);
    beat(3'b000, 5, 5, 32'h800, 32'h4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      a = rnd_op();
      b = ($urandom_range(3) == 0) ? a : rnd_op();
      drive(3'($urandom), a, b, XLEN'($urandom),
            XLEN'($urandom), 1'($urandom));
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.out_ready = ($urandom_range(9) < 7);
      bus.flush     = ($urandom_range(49) == 0);
      tick();
    end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
